// File: rtl/mod_delay_reader.sv
// Modulated fractional delay line: circular sample buffer read back at an LFO-modulated delay
// with two-tap linear interpolation. Define MODDELAY_CLEAR_EN for a zeroing RAM sweep after reset.

module mod_delay_reader #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned BASE_DELAY  = 512,
  parameter int unsigned DEPTH_SHIFT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sampleIn,
  input  logic        sampleValid,
  input  logic [15:0] lfoIn,
  output logic [15:0] sampleOut,
  output logic        sampleOutValid,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned DW    = ADDR_W + 10;
  localparam logic signed [DW-1:0] BASE_Q8 = DW'(BASE_DELAY << 8);
  localparam logic signed [DW-1:0] D_MIN   = DW'(256);
  localparam logic signed [DW-1:0] D_MAX   = DW'((DEPTH - 2) << 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RDA,
    S_RDB,
    S_CAPB,
    S_INTERP,
    S_DONE
`ifdef MODDELAY_CLEAR_EN
    , S_CLEAR
`endif
  } state_e;

`ifdef MODDELAY_CLEAR_EN
  localparam state_e RST_STATE = S_CLEAR;
  localparam logic   RST_BUSY  = 1'b1;
`else
  localparam state_e RST_STATE = S_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [15:0]               smp_q, smp_d;
  logic [15:0]               lfo_q, lfo_d;
  logic [ADDR_W-1:0]         d_int_q, d_int_d;
  logic [7:0]                frac_q, frac_d;
  logic [ADDR_W-1:0]         addr_a_q, addr_a_d;
  logic signed [15:0]        a_q, a_d;
  logic signed [15:0]        b_q, b_d;
  logic signed [15:0]        y_q, y_d;
  logic [15:0]               sample_out_q, sample_out_d;
  logic                      sov_q, sov_d;
  logic                      busy_q, busy_d;
`ifndef MODDELAY_CLEAR_EN
  logic                      primed_q, primed_d;
`endif

  // Single-port buffer with registered read data
  logic [15:0]       mem [DEPTH];
  logic [15:0]       rd_data_q;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [15:0]       ram_wdata_c;

  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      mem[ram_addr_c] <= ram_wdata_c;
    end
    rd_data_q <= mem[ram_addr_c];
  end

  // Delay computation with clamp, and interpolation arithmetic
  logic signed [DW-1:0] lfo_ext_c;
  logic signed [DW-1:0] offset_c;
  logic signed [DW-1:0] delay_raw_c;
  logic signed [DW-1:0] delay_clamp_c;
  logic signed [16:0]   diff_c;
  logic signed [25:0]   prod_c;
  logic signed [15:0]   y_c;

  always_comb begin
    lfo_ext_c   = DW'($signed(lfo_q));
    offset_c    = lfo_ext_c >>> DEPTH_SHIFT;
    delay_raw_c = BASE_Q8 + offset_c;
    if (delay_raw_c < D_MIN) begin
      delay_clamp_c = D_MIN;
    end else if (delay_raw_c > D_MAX) begin
      delay_clamp_c = D_MAX;
    end else begin
      delay_clamp_c = delay_raw_c;
    end
    diff_c = 17'(b_q) - 17'(a_q);
    prod_c = 26'(diff_c) * 26'($signed({1'b0, frac_q}));
    y_c    = a_q + 16'(prod_c >>> 8);
  end

  // Next-state and RAM control
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    smp_d        = smp_q;
    lfo_d        = lfo_q;
    d_int_d      = d_int_q;
    frac_d       = frac_q;
    addr_a_d     = addr_a_q;
    a_d          = a_q;
    b_d          = b_q;
    y_d          = y_q;
    sample_out_d = sample_out_q;
    sov_d        = 1'b0;
`ifndef MODDELAY_CLEAR_EN
    primed_d     = primed_q;
`endif
    ram_we_c     = 1'b0;
    ram_addr_c   = wr_ptr_q;
    ram_wdata_c  = smp_q;

    case (state_q)
      S_IDLE: begin
        if (sampleValid) begin
          smp_d   = sampleIn;
          lfo_d   = lfoIn;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ram_we_c = 1'b1;
        d_int_d  = ADDR_W'(delay_clamp_c >>> 8);
        frac_d   = 8'(delay_clamp_c);
        state_d  = S_RDA;
      end
      S_RDA: begin
        ram_addr_c = wr_ptr_q - d_int_q;
        addr_a_d   = wr_ptr_q - d_int_q;
        state_d    = S_RDB;
      end
      S_RDB: begin
        a_d        = rd_data_q;
        ram_addr_c = addr_a_q - ADDR_W'(1);
        state_d    = S_CAPB;
      end
      S_CAPB: begin
        b_d      = rd_data_q;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
`ifndef MODDELAY_CLEAR_EN
        if (wr_ptr_q == '1) begin
          primed_d = 1'b1;
        end
`endif
        state_d  = S_INTERP;
      end
      S_INTERP: begin
        y_d     = y_c;
        state_d = S_DONE;
      end
      S_DONE: begin
`ifdef MODDELAY_CLEAR_EN
        sample_out_d = y_q;
`else
        // Buffer contents are unknown until every address has been written once
        sample_out_d = primed_q ? y_q : 16'h0000;
`endif
        sov_d   = 1'b1;
        state_d = S_IDLE;
      end
`ifdef MODDELAY_CLEAR_EN
      S_CLEAR: begin
        ram_we_c    = 1'b1;
        ram_wdata_c = 16'h0000;
        wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
        if (wr_ptr_q == '1) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RST_STATE;
      wr_ptr_q     <= '0;
      smp_q        <= '0;
      lfo_q        <= '0;
      d_int_q      <= '0;
      frac_q       <= '0;
      addr_a_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      y_q          <= '0;
      sample_out_q <= '0;
      sov_q        <= 1'b0;
      busy_q       <= RST_BUSY;
`ifndef MODDELAY_CLEAR_EN
      primed_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      smp_q        <= smp_d;
      lfo_q        <= lfo_d;
      d_int_q      <= d_int_d;
      frac_q       <= frac_d;
      addr_a_q     <= addr_a_d;
      a_q          <= a_d;
      b_q          <= b_d;
      y_q          <= y_d;
      sample_out_q <= sample_out_d;
      sov_q        <= sov_d;
      busy_q       <= busy_d;
`ifndef MODDELAY_CLEAR_EN
      primed_q     <= primed_d;
`endif
    end
  end

  assign sampleOut      = sample_out_q;
  assign sampleOutValid = sov_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mod_delay_reader.sv
// Randomized self-checking bench for mod_delay_reader: three instances (nominal, zero and
// oversized base delay) share stimulus and are compared against an ideal sample-history model.

module tb_mod_delay_reader;

  localparam int DEPTH_SHIFT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sampleIn;
  logic        sampleValid;
  logic [15:0] lfoIn;
  logic [15:0] so  [3];
  logic        sov [3];
  logic        bsy [3];

  int errors = 0;
  int checks = 0;
  int base_tab [3] = '{512, 0, 1100};

  int          hist [$];
  int          cur_n;
  int          cur_lfo;
  logic [6:0]  obs_v [3];
  logic [6:0]  obs_b [3];
  int          obs_y [3];
  int          obs_hold [3];

  always #5 clk = ~clk;

  mod_delay_reader #(.ADDR_W(10), .BASE_DELAY(512), .DEPTH_SHIFT(1)) u_dut0 (
    .clk(clk), .reset(reset), .sampleIn(sampleIn), .sampleValid(sampleValid), .lfoIn(lfoIn),
    .sampleOut(so[0]), .sampleOutValid(sov[0]), .busy(bsy[0]));
  mod_delay_reader #(.ADDR_W(10), .BASE_DELAY(0), .DEPTH_SHIFT(1)) u_dut1 (
    .clk(clk), .reset(reset), .sampleIn(sampleIn), .sampleValid(sampleValid), .lfoIn(lfoIn),
    .sampleOut(so[1]), .sampleOutValid(sov[1]), .busy(bsy[1]));
  mod_delay_reader #(.ADDR_W(10), .BASE_DELAY(1100), .DEPTH_SHIFT(1)) u_dut2 (
    .clk(clk), .reset(reset), .sampleIn(sampleIn), .sampleValid(sampleValid), .lfoIn(lfoIn),
    .sampleOut(so[2]), .sampleOutValid(sov[2]), .busy(bsy[2]));

  // Ideal delay line: fractional read into the full history of inputs since reset
  function automatic int exp_y(input int base, input int lfo_s, input int n);
    int d, di, fr, a, b;
    if (n < 1023) return 0;
    d = base * 256 + (lfo_s >>> DEPTH_SHIFT);
    if (d < 256) d = 256;
    if (d > 1022 * 256) d = 1022 * 256;
    di = d / 256;
    fr = d % 256;
    a  = hist[n - di];
    b  = hist[n - di - 1];
    return a + (((b - a) * fr) >>> 8);
  endfunction

  // One accepted sample; records valid/busy after edges 1..7 and the output at edges 6 and 7
  task automatic run_sample(input logic [15:0] x, input logic [15:0] lfo);
    @(negedge clk);
    sampleIn    = x;
    lfoIn       = lfo;
    sampleValid = 1'b1;
    @(posedge clk);
    #1;
    sampleValid = 1'b0;
    hist.push_back(int'($signed(x)));
    cur_n   = hist.size() - 1;
    cur_lfo = int'($signed(lfo));
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        obs_v[i][e-1] = sov[i];
        obs_b[i][e-1] = bsy[i];
        if (e == 6) obs_y[i] = int'($signed(so[i]));
        if (e == 7) obs_hold[i] = int'($signed(so[i]));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; sampleValid = 1'b0; sampleIn = '0; lfoIn = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({so[i], sov[i], bsy[i]} !== 18'h0) begin
        errors++;
        $display("FAIL reset dut%0d out=%h valid=%b busy=%b, want 0/0/0", i, so[i], sov[i], bsy[i]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bsy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy dut%0d busy=%b want 0", i, bsy[i]);
      end
    end
  endtask

  task automatic test_integer_delay();
    int e;
    for (int k = 0; k < 1100; k++) begin
      run_sample(16'(4 * hist.size()), 16'h0000);
      for (int i = 0; i < 3; i++) begin
        e = exp_y(base_tab[i], cur_lfo, cur_n);
        checks += 4;
        if (obs_v[i] !== 7'b0100000) begin errors++; $display("FAIL int_valid dut%0d n=%0d got=%b want=0100000", i, cur_n, obs_v[i]); end
        if (obs_b[i] !== 7'b0011111) begin errors++; $display("FAIL int_busy dut%0d n=%0d got=%b want=0011111", i, cur_n, obs_b[i]); end
        if (obs_y[i] !== e) begin errors++; $display("FAIL int_out dut%0d n=%0d got=%0d want=%0d", i, cur_n, obs_y[i], e); end
        if (obs_hold[i] !== e) begin errors++; $display("FAIL int_hold dut%0d n=%0d got=%0d want=%0d", i, cur_n, obs_hold[i], e); end
      end
      if (cur_n >= 1023) begin
        checks++;
        if (obs_y[0] !== 4 * (cur_n - 512)) begin
          errors++; $display("FAIL int_ramp n=%0d got=%0d want=%0d", cur_n, obs_y[0], 4 * (cur_n - 512));
        end
      end
    end
  endtask

  task automatic test_fractional_delay();
    int e;
    for (int k = 0; k < 60; k++) begin
      run_sample(16'(4 * hist.size()), 16'd256);
      for (int i = 0; i < 3; i++) begin
        e = exp_y(base_tab[i], cur_lfo, cur_n);
        checks += 2;
        if (obs_v[i] !== 7'b0100000) begin errors++; $display("FAIL frac_valid dut%0d n=%0d got=%b want=0100000", i, cur_n, obs_v[i]); end
        if (obs_y[i] !== e) begin errors++; $display("FAIL frac_out dut%0d n=%0d got=%0d want=%0d", i, cur_n, obs_y[i], e); end
      end
      checks++;
      if (obs_y[0] !== 4 * (cur_n - 512) - 2) begin
        errors++; $display("FAIL frac_ramp n=%0d got=%0d want=%0d", cur_n, obs_y[0], 4 * (cur_n - 512) - 2);
      end
    end
  endtask

  task automatic test_random_lfo();
    int e;
    logic [15:0] lfo;
    for (int k = 0; k < 300; k++) begin
      lfo = (k % 4 == 0) ? 16'h8000 : 16'($urandom_range(0, 65535));
      run_sample(16'($urandom_range(0, 65535)), lfo);
      for (int i = 0; i < 3; i++) begin
        e = exp_y(base_tab[i], cur_lfo, cur_n);
        checks += 3;
        if (obs_v[i] !== 7'b0100000) begin errors++; $display("FAIL rnd_valid dut%0d n=%0d got=%b want=0100000", i, cur_n, obs_v[i]); end
        if (obs_b[i] !== 7'b0011111) begin errors++; $display("FAIL rnd_busy dut%0d n=%0d got=%b want=0011111", i, cur_n, obs_b[i]); end
        if (obs_y[i] !== e) begin errors++; $display("FAIL rnd_out dut%0d n=%0d got=%0d want=%0d", i, cur_n, obs_y[i], e); end
      end
      checks++;
      if (obs_y[2] !== hist[cur_n - 1022]) begin
        errors++; $display("FAIL clamp_hi n=%0d got=%0d want=%0d", cur_n, obs_y[2], hist[cur_n - 1022]);
      end
      if (lfo == 16'h8000) begin
        checks++;
        if (obs_y[1] !== hist[cur_n - 1]) begin
          errors++; $display("FAIL clamp_lo n=%0d got=%0d want=%0d", cur_n, obs_y[1], hist[cur_n - 1]);
        end
      end
    end
  endtask

  task automatic test_overlap();
    int cnt [3];
    int yv [3];
    int e;
    @(negedge clk);
    sampleIn = 16'h1234; lfoIn = 16'h0000; sampleValid = 1'b1;
    @(posedge clk);
    #1;
    sampleValid = 1'b0;
    hist.push_back(int'($signed(16'h1234)));
    cur_n = hist.size() - 1;
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; yv[i] = 0; end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) begin
        sampleIn = 16'h7abc; lfoIn = 16'h8000; sampleValid = 1'b1;
      end else begin
        sampleValid = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (sov[i]) begin cnt[i]++; yv[i] = int'($signed(so[i])); end
      end
    end
    sampleValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = exp_y(base_tab[i], 0, cur_n);
      checks += 2;
      if (cnt[i] !== 1) begin errors++; $display("FAIL overlap_pulses dut%0d got=%0d want=1", i, cnt[i]); end
      if (yv[i] !== e) begin errors++; $display("FAIL overlap_out dut%0d got=%0d want=%0d", i, yv[i], e); end
    end
  endtask

  task automatic test_wrap();
    int e, seg0, prev;
    seg0 = hist.size();
    prev = 0;
    while (hist.size() < 2160) begin
      run_sample(16'(4 * hist.size()), 16'h0000);
      for (int i = 0; i < 3; i++) begin
        e = exp_y(base_tab[i], cur_lfo, cur_n);
        checks += 2;
        if (obs_v[i] !== 7'b0100000) begin errors++; $display("FAIL wrap_valid dut%0d n=%0d got=%b want=0100000", i, cur_n, obs_v[i]); end
        if (obs_y[i] !== e) begin errors++; $display("FAIL wrap_out dut%0d n=%0d got=%0d want=%0d", i, cur_n, obs_y[i], e); end
      end
      if (cur_n >= seg0 + 513) begin
        checks++;
        if (obs_y[0] - prev !== 4) begin
          errors++; $display("FAIL wrap_step n=%0d got=%0d want=4", cur_n, obs_y[0] - prev);
        end
      end
      prev = obs_y[0];
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    int e;
    @(negedge clk);
    sampleIn = 16'h4321; lfoIn = 16'h0000; sampleValid = 1'b1;
    @(posedge clk);
    #1;
    sampleValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({so[i], sov[i], bsy[i]} !== 18'h0) begin
        errors++;
        $display("FAIL midrst dut%0d out=%h valid=%b busy=%b, want 0/0/0", i, so[i], sov[i], bsy[i]);
      end
    end
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) reset = 1'b1;
      for (int i = 0; i < 3; i++) cnt += int'(sov[i]);
    end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL midrst_pulses got=%0d want=0", cnt); end
    hist.delete();
    for (int k = 0; k < 1030; k++) begin
      run_sample(16'(3 * hist.size() + 7), 16'($urandom_range(0, 65535)));
      for (int i = 0; i < 3; i++) begin
        e = exp_y(base_tab[i], cur_lfo, cur_n);
        checks += 2;
        if (obs_v[i] !== 7'b0100000) begin errors++; $display("FAIL post_valid dut%0d n=%0d got=%b want=0100000", i, cur_n, obs_v[i]); end
        if (obs_y[i] !== e) begin errors++; $display("FAIL post_out dut%0d n=%0d got=%0d want=%0d", i, cur_n, obs_y[i], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_integer_delay();
    test_fractional_delay();
    test_random_lfo();
    test_overlap();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
